// File: rtl/alu_pkg.sv
// Shared definitions for the two-requester ALU arbiter: opcodes, FSM states,
// and the divide/remainder special-case result patching.
package alu_pkg;

  localparam int unsigned OP_W   = 5;
  localparam int unsigned DATA_W = 32;

  localparam logic [OP_W-1:0] OP_ADD  = 5'b00000;
  localparam logic [OP_W-1:0] OP_SUB  = 5'b00001;
  localparam logic [OP_W-1:0] OP_AND  = 5'b00010;
  localparam logic [OP_W-1:0] OP_OR   = 5'b00011;
  localparam logic [OP_W-1:0] OP_XOR  = 5'b00100;
  localparam logic [OP_W-1:0] OP_SLL  = 5'b00101;
  localparam logic [OP_W-1:0] OP_SRL  = 5'b00110;
  localparam logic [OP_W-1:0] OP_SRA  = 5'b00111;
  localparam logic [OP_W-1:0] OP_SLT  = 5'b01000;
  localparam logic [OP_W-1:0] OP_SLTU = 5'b01001;
  localparam logic [OP_W-1:0] OP_MUL  = 5'b01010;
  localparam logic [OP_W-1:0] OP_DIV  = 5'b11010;
  localparam logic [OP_W-1:0] OP_DIVU = 5'b11011;
  localparam logic [OP_W-1:0] OP_REM  = 5'b11100;
  localparam logic [OP_W-1:0] OP_REMU = 5'b11101;
  localparam logic [OP_W-1:0] OP_ILL0 = 5'b11110;
  localparam logic [OP_W-1:0] OP_ILL1 = 5'b11111;

  localparam logic [DATA_W-1:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [DATA_W-1:0] DIV_OVF_A     = 32'h8000_0000;
  localparam logic [DATA_W-1:0] DIV_OVF_B     = 32'hFFFF_FFFF;
  localparam logic [DATA_W-1:0] DIV_OVF_Q     = 32'h8000_0000;
  localparam logic [DATA_W-1:0] DIV_OVF_R     = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              err;
  } result_t;

  // The external ALU result is trusted except for the corner cases below.
  function automatic result_t fix_result(input logic [OP_W-1:0]   op,
                                         input logic [DATA_W-1:0] a,
                                         input logic [DATA_W-1:0] b,
                                         input logic [DATA_W-1:0] alu_res);
    result_t r;
    logic    b_zero;
    logic    ovf;
    b_zero = (b == '0);
    ovf    = (a == DIV_OVF_A) && (b == DIV_OVF_B);
    r.data = alu_res;
    r.err  = 1'b0;
    case (op)
      OP_DIV: begin
        if (b_zero)   r.data = DIV_BY_ZERO_Q;
        else if (ovf) r.data = DIV_OVF_Q;
      end
      OP_DIVU: if (b_zero) r.data = DIV_BY_ZERO_Q;
      OP_REM: begin
        if (b_zero)   r.data = a;
        else if (ovf) r.data = DIV_OVF_R;
      end
      OP_REMU: if (b_zero) r.data = a;
      OP_ILL0, OP_ILL1: begin
        r.data = '0;
        r.err  = 1'b1;
      end
      default: ;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way grant logic. Round-robin by default; ALU_ARB_FIXED_PRIO_EN selects
// fixed priority (requester 0 always wins) and removes the last-grant register.
module rr_arb2
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid_i,
  input  logic       accept_i,
  output logic [1:0] grant_o
);

`ifdef ALU_ARB_FIXED_PRIO_EN
  logic unused_ok;
  assign unused_ok = ^{clk, rst_n, accept_i};
  assign grant_o   = {valid_i[1] & ~valid_i[0], valid_i[0]};
`else
  logic last_q;
  logic last_d;

  // last_q holds the index granted most recently; the other one wins a tie.
  always_comb begin
    grant_o = valid_i;
    if (valid_i == 2'b11) grant_o = last_q ? 2'b01 : 2'b10;
    last_d = last_q;
    if (accept_i) last_d = grant_o[1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= 1'b1;
    else        last_q <= last_d;
  end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two requesters: accept, one
// execute cycle, then hold the response until the owner takes it.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int ID_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [4:0]      req_op0,
  input  logic [4:0]      req_op1,
  input  logic [31:0]     req_a0,
  input  logic [31:0]     req_b0,
  input  logic [31:0]     req_a1,
  input  logic [31:0]     req_b1,
  input  logic [ID_W-1:0] req_tag0,
  input  logic [ID_W-1:0] req_tag1,
  output logic [31:0]     alu_a,
  output logic [31:0]     alu_b,
  output logic [4:0]      alu_op,
  input  logic [31:0]     alu_out,
  output logic [1:0]      rsp_valid,
  input  logic [1:0]      rsp_ready,
  output logic [31:0]     rsp_data,
  output logic [ID_W-1:0] rsp_tag,
  output logic            rsp_err,
  output logic            rsp_zero,
  output state_t          dbg_state_o
);

  // Handshake rule on both channels: a transfer happens at a rising edge where
  // valid and ready are both 1; valid never depends on ready.
  state_t          state_q;
  logic            owner_q;
  logic [4:0]      op_q;
  logic [31:0]     a_q;
  logic [31:0]     b_q;
  logic [ID_W-1:0] tag_q;
  logic [1:0]      rsp_valid_q;
  logic [31:0]     rsp_data_q;
  logic [ID_W-1:0] rsp_tag_q;
  logic            rsp_err_q;
  logic            rsp_zero_q;

  logic [1:0] grant;
  logic       accept;
  logic       sel;
  result_t    res;

  rr_arb2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid_i  (req_valid),
    .accept_i (accept),
    .grant_o  (grant)
  );

  assign req_ready = (rst_n && state_q == ST_IDLE) ? (req_valid & grant) : 2'b00;
  assign accept    = |req_ready;
  assign sel       = req_ready[1];
  assign res       = fix_result(op_q, a_q, b_q, alu_out);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      owner_q     <= 1'b0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      tag_q       <= '0;
      rsp_valid_q <= 2'b00;
      rsp_data_q  <= '0;
      rsp_tag_q   <= '0;
      rsp_err_q   <= 1'b0;
      rsp_zero_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            owner_q <= sel;
            op_q    <= sel ? req_op1  : req_op0;
            a_q     <= sel ? req_a1   : req_a0;
            b_q     <= sel ? req_b1   : req_b0;
            tag_q   <= sel ? req_tag1 : req_tag0;
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_data_q  <= res.data;
          rsp_err_q   <= res.err;
          rsp_zero_q  <= (res.data == '0);
          rsp_tag_q   <= tag_q;
          rsp_valid_q <= owner_q ? 2'b10 : 2'b01;
          state_q     <= ST_HOLD;
        end
        ST_HOLD: begin
          if (rsp_ready[owner_q]) begin
            rsp_valid_q <= 2'b00;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign alu_op      = op_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_tag     = rsp_tag_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_zero    = rsp_zero_q;
  assign dbg_state_o = state_q;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter ID_W, default 4, width of the requester transaction tag.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports req_valid / req_ready  input / output  2  per-requester request handshake; bit i is requester i.
REQ-005 SHALL have ports req_op0, req_op1  input  5  ALU opcode per requester.
REQ-006 SHALL have ports req_a0, req_b0, req_a1, req_b1  input  32  operands per requester.
REQ-007 SHALL have ports req_tag0, req_tag1  input  ID_W  tag, returned unchanged with the response.
REQ-008 SHALL have ports alu_a, alu_b  output  32  and alu_op  output  5, which drive the shared combinational ALU.
REQ-009 SHALL have port alu_out  input  32  ALU result.
REQ-010 SHALL have ports rsp_valid / rsp_ready  output / input  2  per-requester response handshake.
REQ-011 SHALL have ports rsp_data  output  32, rsp_tag  output  ID_W, rsp_err  output  1 (illegal opcode), and rsp_zero  output  1 (rsp_data == 0).

Function
REQ-012 SHALL implement FSM states IDLE, EXEC and HOLD.
REQ-013 IDLE: req_ready[i] SHALL equal req_valid[i] AND grant[i]; at most one bit is set per cycle.
REQ-014 Accept in IDLE: latch the granted requester's op, a, b, tag and owner index into registers; next state is EXEC.
REQ-015 alu_a, alu_b and alu_op SHALL be driven only from the latched registers, never directly from req_* ports.
REQ-016 EXEC (one cycle): capture the result into the response register; next state is HOLD.
REQ-017 HOLD: rsp_valid[owner] SHALL be 1 and the other bit 0; rsp_data, rsp_tag, rsp_err and rsp_zero SHALL remain stable until rsp_ready[owner] is 1, then the next state is IDLE.
REQ-018 Latency: a request accepted at edge N SHALL have rsp_valid asserted from edge N+2; peak throughput is one operation per 3 cycles.
REQ-019 Round-robin arbitration: if both requesters are valid, the one not granted last SHALL win; a single valid requester always wins; last-grant updates only on acceptance.
REQ-020 Divide by zero (b == 0): DIV/DIVU SHALL return 32'hFFFFFFFF and REM/REMU SHALL return a, overriding alu_out.
REQ-021 Signed overflow (a == 32'h80000000, b == 32'hFFFFFFFF): DIV SHALL return 32'h80000000 and REM SHALL return 0.
REQ-022 Opcodes 5'b11110 and 5'b11111 SHALL return rsp_data = 0 with rsp_err = 1; rsp_err SHALL be 0 for all other opcodes.
REQ-023 rsp_ready on the non-owner bit, and in any state other than HOLD, SHALL be ignored.
REQ-024 In EXEC and HOLD, req_ready SHALL be 2'b00; requests remain pending and are not dropped.

Reset
REQ-025 On rst_n low: state = IDLE, req_ready = 0, rsp_valid = 0, and rsp_data, rsp_tag, rsp_err, rsp_zero, alu_a, alu_b, alu_op = 0.
REQ-026 On rst_n low: last-grant SHALL be set to 1, so requester 0 wins the first contention.
REQ-027 Reset asserted in EXEC or HOLD SHALL abandon the transaction; no response is ever issued for it.

Configuration
REQ-028 Macro ALU_ARB_FIXED_PRIO_EN defined: requester 0 SHALL always win contention and the last-grant register is absent.
REQ-029 Macro ALU_ARB_FIXED_PRIO_EN undefined: round-robin per REQ-019.

Structure
REQ-030 Package alu_pkg SHALL hold the 5-bit opcode constants (ADD = 0 ... REMU = 5'b11101), the FSM state enum, and the div/rem special-case constants.
REQ-031 The two-way grant logic, including the last-grant register, SHALL be a sub-module rr_arb2; the ALU itself stays external.

Verification
REQ-032 Single request: requester 0 valid with op ADD, a = 5, b = 7, tag = 3 -> rsp_valid[0] at N+2, rsp_data = 12, rsp_tag = 3, rsp_zero = 0.
REQ-033 Contention: both requesters valid continuously, rsp_ready = 1 -> grants alternate 0,1,0,1, or 0,0,0,0 with ALU_ARB_FIXED_PRIO_EN.
REQ-034 DIVU with a = 9, b = 0 -> 32'hFFFFFFFF; REM with a = -7, b = 0 -> 32'hFFFFFFF9; DIV with a = 32'h80000000, b = -1 -> 32'h80000000.
REQ-035 Backpressure: rsp_ready[1] held 0 for 5 cycles during HOLD -> outputs stable and req_ready = 0 throughout; release -> IDLE next cycle.
REQ-036 Opcode 5'b11111 -> rsp_err = 1, rsp_data = 0; SUB with a = 4, b = 4 -> rsp_zero = 1.
REQ-037 rst_n pulsed low during HOLD -> rsp_valid = 0 immediately (asynchronously); the next request is served normally and requester 0 wins contention.
